// File: rtl/sonar_pkg.sv
// sonar_pkg: shared sonar types and constants (receiver FSM states, quadrature phase count, carrier/clock rates)
package sonar_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, LISTEN} rx_state_t;
  localparam int NUM_PHASES = 4;
  localparam int TARGET_FREQ = 40000;
  localparam int CLK_FREQ = 100000000;
endpackage

// File: rtl/iq_accumulator.sv
// iq_accumulator: quadrature correlator over WINDOW samples taken at 4x the carrier
// ports: clk, rst_n (sync, active-low), clear (zero accumulators, phase, count),
//        sample_valid/sample_in (signed 16-bit sample strobe),
//        i_acc/q_acc (final I/Q of the last window), window_done (pulse when i_acc/q_acc update)
module iq_accumulator import sonar_pkg::*; #(
  parameter int WINDOW = 64,
  parameter int ACC_W = 16 + $clog2(WINDOW)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    sample_valid,
  input  logic signed [15:0]      sample_in,
  output logic signed [ACC_W-1:0] i_acc,
  output logic signed [ACC_W-1:0] q_acc,
  output logic                    window_done
);
  localparam int PW = $clog2(NUM_PHASES);
  localparam int CW = $clog2(WINDOW);
  logic [PW-1:0] phase;
  logic [CW-1:0] count;
  logic signed [ACC_W-1:0] i_run, q_run, s_ext, term, i_next, q_next;
  logic last;
  assign s_ext = ACC_W'(sample_in);
  assign last = count == CW'(WINDOW - 1);
  // phases 0/1 add into I/Q, phases 2/3 subtract; phase[0] selects Q
  always_comb begin
    term = phase[1] ? -s_ext : s_ext;
    i_next = phase[0] ? i_run : i_run + term;
    q_next = phase[0] ? q_run + term : q_run;
  end
  always_ff @(posedge clk)
    if (!rst_n || clear) begin
      phase <= '0;
      count <= '0;
      i_run <= '0;
      q_run <= '0;
      i_acc <= '0;
      q_acc <= '0;
      window_done <= 1'b0;
    end else begin
      window_done <= sample_valid && last;
      if (sample_valid) begin
        phase <= phase + PW'(1);
        count <= count + CW'(1);
        i_run <= last ? '0 : i_next;
        q_run <= last ? '0 : q_next;
        if (last) begin
          i_acc <= i_next;
          q_acc <= q_next;
        end
      end
    end
endmodule

// File: rtl/echo_receiver.sv
// echo_receiver: sonar echo detector reporting time-of-flight or timeout after a transmit burst
// ports: clk, rst_n (sync, active-low), sample_in/sample_valid (160 kHz echo samples),
//        tx_start (burst start pulse), threshold (detection level),
//        tof_cycles/tof_valid (detection result), timeout (no-echo pulse), busy (listening),
//        magnitude/mag_valid (|I|+|Q| per completed window)
module echo_receiver import sonar_pkg::*; #(
  parameter int          WINDOW         = 64,
  parameter logic [31:0] BLANK_CYCLES   = 32'd50000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd3000000,
  parameter int          ACC_W          = 16 + $clog2(WINDOW)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] sample_in,
  input  logic               sample_valid,
  input  logic               tx_start,
  input  logic [31:0]        threshold,
  output logic [31:0]        tof_cycles,
  output logic               tof_valid,
  output logic               timeout,
  output logic               busy,
  output logic [31:0]        magnitude,
  output logic               mag_valid
);
  rx_state_t state, state_next;
  logic [31:0] counter, counter_d, mag_now;
  logic signed [ACC_W-1:0] i_acc, q_acc;
  logic [ACC_W-1:0] abs_i, abs_q;
  logic [ACC_W:0] mag_sum;
  logic window_done, clear, take;
  assign clear = state == BLANK && counter == BLANK_CYCLES && !tx_start;
  iq_accumulator #(.WINDOW(WINDOW), .ACC_W(ACC_W)) u_acc (
    .clk,
    .rst_n,
    .clear,
    .sample_valid(sample_valid && state == LISTEN),
    .sample_in,
    .i_acc,
    .q_acc,
    .window_done
  );
  // ACC_W-bit unsigned abs holds 2^(ACC_W-1); the extra sum bit makes full scale overflow-free
  assign abs_i = i_acc[ACC_W-1] ? -i_acc : i_acc;
  assign abs_q = q_acc[ACC_W-1] ? -q_acc : q_acc;
  assign mag_sum = {1'b0, abs_i} + {1'b0, abs_q};
  assign mag_now = 32'(mag_sum);
  assign busy = state != IDLE;
  assign timeout = state == LISTEN && counter == TIMEOUT_CYCLES && !tof_valid;
  // a finished window is dropped on restart or when listening is abandoned this cycle
  assign take = state == LISTEN && window_done && !tx_start && !timeout;
  always_comb
    state_next = tx_start ? BLANK :
                 clear ? LISTEN :
                 (state == LISTEN && (tof_valid || timeout)) ? IDLE : state;
  // counter_d lags counter so it holds the timestamp of the window's last sample when window_done arrives
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      counter <= '0;
      counter_d <= '0;
      magnitude <= '0;
      mag_valid <= 1'b0;
      tof_valid <= 1'b0;
      tof_cycles <= '0;
    end else begin
      state <= state_next;
      counter <= tx_start ? 32'd1 : (busy && counter != '1) ? counter + 32'd1 : counter;
      counter_d <= counter;
      mag_valid <= take;
      tof_valid <= take && mag_now >= threshold;
      if (take) magnitude <= mag_now;
      if (take && mag_now >= threshold) tof_cycles <= counter_d;
    end
endmodule

// File: tb/tb_echo_receiver.sv
// tb_echo_receiver: directed table-driven checks of echo_receiver plus reset and restart sequences
module tb_echo_receiver;
  localparam int BLANK = 100;
  localparam int TMO = 20000;
  logic clk = 0, rst_n = 0, sample_valid = 0, tx_start = 0;
  logic signed [15:0] sample_in = 0;
  logic [31:0] threshold = 0, tof_cycles, magnitude;
  logic tof_valid, timeout, busy, mag_valid;
  typedef struct {
    logic signed [15:0] p0, p1, p2, p3;
    logic [31:0] thr;
    logic [31:0] mag;
    bit det;
    bit blank_only;
  } vec_t;
  vec_t vecs[6];
  logic signed [15:0] pat[4];
  bit blank_only = 0, active = 0;
  int cyc = 0, t0 = 0, n_listen = 0, checks = 0, passes = 0;
  int win_q[$];
  echo_receiver #(.WINDOW(64), .BLANK_CYCLES(32'd100), .TIMEOUT_CYCLES(32'd20000)) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .tx_start(tx_start), .threshold(threshold), .tof_cycles(tof_cycles), .tof_valid(tof_valid),
    .timeout(timeout), .busy(busy), .magnitude(magnitude), .mag_valid(mag_valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    int div = 0, k = 0;
    forever begin
      @(negedge clk);
      sample_valid = div == 0;
      if (div == 0) begin
        sample_in = (blank_only && cyc > t0 + BLANK) ? 16'sd0 : pat[k];
        k = (k + 1) % 4;
      end
      div = (div + 1) % 4;
    end
  end
  // reference model of window boundaries: the cycle of every 64th sample accepted after blanking
  initial forever begin
    @(posedge clk);
    if (active && sample_valid && cyc >= t0 + BLANK + 1) begin
      n_listen++;
      if (n_listen % 64 == 0) win_q.push_back(cyc);
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act === exp_v) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
  endtask
  task automatic start();
    tx_start = 1;
    t0 = cyc;
    win_q.delete();
    n_listen = 0;
    active = 1;
    @(negedge clk);
    tx_start = 0;
    chk("busy_rise", busy, 1);
  endtask
  task automatic run_to_end(input logic [31:0] exp_mag, input bit exp_det);
    bit done = 0;
    int lim = 0, last_n = -1, busy_bad = 0;
    while (!done && lim < 25000) begin
      if (!busy) busy_bad++;
      if (mag_valid) begin
        last_n = win_q.size() > 0 ? win_q.pop_front() : -1;
        chk("mag_cycle", cyc, last_n + 2);
        chk("magnitude", magnitude, exp_mag);
      end
      if (tof_valid) chk("tof_cycles", tof_cycles, last_n - t0);
      if (tof_valid || timeout) begin
        chk("detect", tof_valid, exp_det);
        chk("timeout", timeout, !exp_det);
        if (timeout) chk("timeout_at", cyc - t0, TMO);
        done = 1;
      end
      @(negedge clk);
      lim++;
    end
    chk("finished", done, 1);
    chk("busy_hold", busy_bad, 0);
    chk("busy_fall", busy, 0);
    chk("no_extra_pulse", {tof_valid, timeout}, 0);
  endtask
  initial begin
    int quiet, sz;
    vecs[0] = '{16'sd10000, 16'sd0, -16'sd10000, 16'sd0, 32'd100000, 32'd320000, 1'b1, 1'b0};
    vecs[1] = '{16'sd10000, 16'sd0, -16'sd10000, 16'sd0, 32'd320000, 32'd320000, 1'b1, 1'b0};
    vecs[2] = '{-16'sd32768, 16'sd0, 16'sd32767, 16'sd0, 32'd1048560, 32'd1048560, 1'b1, 1'b0};
    vecs[3] = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 32'd0, 32'd0, 1'b1, 1'b0};
    vecs[4] = '{16'sd20000, 16'sd20000, 16'sd20000, 16'sd20000, 32'd1, 32'd0, 1'b0, 1'b0};
    vecs[5] = '{16'sd10000, 16'sd0, -16'sd10000, 16'sd0, 32'd100000, 32'd0, 1'b0, 1'b1};
    repeat (3) @(negedge clk);
    chk("rst_tof_cycles", tof_cycles, 0);
    chk("rst_tof_valid", tof_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_magnitude", magnitude, 0);
    chk("rst_mag_valid", mag_valid, 0);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      pat[0] = vecs[i].p0;
      pat[1] = vecs[i].p1;
      pat[2] = vecs[i].p2;
      pat[3] = vecs[i].p3;
      threshold = vecs[i].thr;
      blank_only = vecs[i].blank_only;
      start();
      run_to_end(vecs[i].mag, vecs[i].det);
    end
    blank_only = 0;
    pat[0] = 16'sd10000; pat[1] = 16'sd0; pat[2] = -16'sd10000; pat[3] = 16'sd0;
    threshold = 32'hFFFF_FFFF;
    start();
    repeat (400) @(negedge clk);
    chk("mag_before_reset", magnitude, 320000);
    rst_n = 0;
    active = 0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_magnitude", magnitude, 0);
    chk("reset_tof_cycles", tof_cycles, 0);
    chk("reset_pulses", {mag_valid, tof_valid, timeout}, 0);
    rst_n = 1;
    quiet = 0;
    repeat (600) begin
      @(negedge clk);
      if (busy || mag_valid || tof_valid || timeout) quiet++;
    end
    chk("quiet_after_reset", quiet, 0);
    threshold = 32'd100000;
    start();
    sz = 0;
    for (int w = 0; w < 1000 && sz == 0; w++) begin
      @(negedge clk);
      sz = win_q.size();
    end
    chk("restart_window_seen", sz, 1);
    start();
    chk("restart_no_tof", tof_valid, 0);
    chk("restart_no_mag", mag_valid, 0);
    run_to_end(32'd320000, 1'b1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
